qft_pulse_decoder: RTL and testbench

Receiving end of the QFT probability pulse train: samples the square-wave `sq` line driven by the QFT display generator and decodes its eight amplitude-squared pulse widths back into Q2.15 probabilities. It sits on the capture board, downstream of an FPGA pin, and feeds result registers and display logic. Zero-probability slots emit no pulse, so the block re-derives slot positions from quantised low-run lengths.

---
 rtl/qft_pulse_decoder_pkg.sv | 13 +
 rtl/qft_pulse_decoder_if.sv | 13 +
 rtl/qft_pulse_decoder_gap_quantizer.sv | 25 ++
 rtl/qft_pulse_decoder.sv | 130 +++++++++++++
 tb/tb_qft_pulse_decoder.sv | 119 +++++++++++
 5 files changed

// File: rtl/qft_pulse_decoder_pkg.sv
// qft_rx_pkg: shared types, sizes and the width-to-probability conversion for the pulse decoder
package qft_rx_pkg;
  typedef enum logic [1:0] {HUNT, PULSE, SPACE} state_t;
  localparam int NSLOT = 8;
  localparam int PW = 17;
  localparam int WW = 32;
  localparam logic [PW-1:0] PSAT = 17'h0FFFF;
  function automatic logic [PW-1:0] to_prob(input logic [WW-1:0] w, input logic [31:0] recip, input int rshift);
    logic [63:0] p;
    p = (64'(w) * 64'(recip) + (64'd1 << (rshift - 1))) >> rshift;
    return p > 64'(PSAT) ? PSAT : p[PW-1:0];
  endfunction
endpackage

// File: rtl/qft_pulse_decoder_if.sv
// qft_pulse_decoder_if: pulse line, slot selector and decoded result bank
interface qft_pulse_decoder_if;
  import qft_rx_pkg::*;
  logic sq_in;
  logic [2:0] slot_sel;
  logic [NSLOT*PW-1:0] prob;
  logic [WW-1:0] slot_width;
  logic frame_valid;
  logic locked;
  logic sync_err;
  modport master (output sq_in, slot_sel, input prob, slot_width, frame_valid, locked, sync_err);
  modport slave (input sq_in, slot_sel, output prob, slot_width, frame_valid, locked, sync_err);
endinterface

// File: rtl/qft_pulse_decoder_gap_quantizer.sv
// gap_quantizer: rounds a low-run length to whole GAP periods, q = floor((L+GAP/2)/GAP), saturating at 31
module gap_quantizer #(
  parameter int GAP = 5_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  output logic [4:0] q
);
  localparam logic [31:0] HALF = 32'(GAP / 2);
  localparam logic [31:0] LAST = 32'(GAP - 1);
  logic [31:0] sub;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sub <= '0;
      q <= '0;
    end else if (start) begin
      sub <= HALF;
      q <= '0;
    end else if (run) begin
      sub <= sub == LAST ? '0 : sub + 1'b1;
      q <= q + {4'b0, sub == LAST && q != 5'd31};
    end
endmodule

// File: rtl/qft_pulse_decoder.sv
// qft_pulse_decoder: recovers eight Q2.15 probabilities from the pulse-width train on sq_in
module qft_pulse_decoder
  import qft_rx_pkg::*;
#(
  parameter int GAP = 5_500_000,
  parameter int RECIP = 3_518_437,
  parameter int RSHIFT = 32
) (
  input logic clk,
  input logic rst,
  qft_pulse_decoder_if.slave bus
);
  logic sq_m, sq_s, sq_d, fall, rise;
  logic [WW-1:0] wcnt, mul_w;
  logic [4:0] q;
  logic [5:0] qs;
  state_t state, state_n;
  logic [2:0] s, s_n, mul_s;
  logic done, done_n, mul_go;
  logic hunt_ok, adv_ok, wrap_ok, complete, too_long, space_err;
  logic lock_set, wr, pub, err;
  logic [PW-1:0] p_mul;
  logic [WW-1:0] work_w [NSLOT];
  logic [WW-1:0] pub_w [NSLOT];
  logic [WW-1:0] ww_n [NSLOT];
  logic [PW-1:0] work_p [NSLOT];
  logic [PW-1:0] wp_n [NSLOT];
  assign fall = sq_d & ~sq_s;
  assign rise = ~sq_d & sq_s;
  assign qs = {1'b0, q} + {3'b0, s};
  assign hunt_ok = rise && q >= 5'd10 && q <= 5'd17;
  assign adv_ok = q != 5'd0 && qs <= 6'd7;
  assign wrap_ok = qs >= 6'd17 && qs <= 6'd24;
  assign complete = !done && qs == 6'd9;
  assign too_long = !sq_s && qs > 6'd24;
  assign space_err = (rise && (done ? !wrap_ok : !adv_ok)) || too_long;
  assign p_mul = to_prob(mul_w, 32'(RECIP), RSHIFT);
  gap_quantizer #(.GAP(GAP)) u_gq (.clk(clk), .rst(rst), .start(fall), .run(~sq_s), .q(q));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sq_m <= 1'b0;
      sq_s <= 1'b0;
      sq_d <= 1'b0;
      wcnt <= '0;
    end else begin
      sq_m <= bus.sq_in;
      sq_s <= sq_m;
      sq_d <= sq_s;
      wcnt <= rise ? WW'(1) : (sq_s && wcnt != '1) ? wcnt + 1'b1 : wcnt;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HUNT;
      s <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      s <= s_n;
      done <= done_n;
    end
  // q-10 and q+s-17 reduce to q-2 and q+s-1 modulo the eight slots
  always_comb begin
    state_n = state;
    s_n = s;
    done_n = done;
    if (state == HUNT) begin
      if (hunt_ok) begin
        state_n = PULSE;
        s_n = q[2:0] - 3'd2;
      end
    end else if (state == PULSE) begin
      if (fall) begin
        state_n = SPACE;
        done_n = 1'b0;
      end
    end else if (space_err) begin
      state_n = HUNT;
    end else if (rise) begin
      state_n = PULSE;
      s_n = done ? qs[2:0] - 3'd1 : qs[2:0];
    end else if (complete) begin
      done_n = 1'b1;
    end
  end
  always_comb begin
    lock_set = state == HUNT && hunt_ok;
    wr = state == PULSE && fall;
    pub = state == SPACE && !rise && complete;
    err = state == SPACE && space_err;
  end
  // a multiply landing in the publish cycle is forwarded into the published copy
  always_comb begin
    for (int k = 0; k < NSLOT; k++) begin
      ww_n[k] = (wr && s == 3'(k)) ? wcnt : work_w[k];
      wp_n[k] = (mul_go && mul_s == 3'(k)) ? p_mul : work_p[k];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.locked <= 1'b0;
      bus.sync_err <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.prob <= '0;
      bus.slot_width <= '0;
      mul_go <= 1'b0;
      mul_w <= '0;
      mul_s <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        work_w[k] <= '0;
        pub_w[k] <= '0;
        work_p[k] <= '0;
      end
    end else begin
      bus.locked <= lock_set | (bus.locked & ~err);
      bus.sync_err <= err;
      bus.frame_valid <= pub;
      bus.slot_width <= pub ? ww_n[bus.slot_sel] : pub_w[bus.slot_sel];
      mul_go <= wr;
      mul_w <= wcnt;
      mul_s <= s;
      for (int k = 0; k < NSLOT; k++) begin
        work_w[k] <= (pub || lock_set) ? '0 : ww_n[k];
        work_p[k] <= (pub || lock_set) ? '0 : wp_n[k];
        if (pub) begin
          pub_w[k] <= ww_n[k];
          bus.prob[k*PW +: PW] <= wp_n[k];
        end
      end
    end
endmodule

// File: tb/tb_qft_pulse_decoder.sv
// tb_qft_pulse_decoder: directed frames with hand-computed banks (GAP=64, p equals width)
module tb_qft_pulse_decoder;
  import qft_rx_pkg::*;
  localparam int GAP = 64;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int fa [8] = '{100, 300, 0, 0, 0, 0, 0, 50};
  int fi [8] = '{50, 0, 70, 0, 0, 0, 0, 90};
  int fl [8] = '{0, 0, 40, 0, 0, 0, 0, 25};
  int fs [8] = '{70000, 0, 0, 0, 0, 0, 0, 10};
  qft_pulse_decoder_if bus();
  qft_pulse_decoder #(.GAP(GAP), .RECIP(65536), .RSHIFT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.frame_valid) fv_cnt++;
    if (bus.sync_err) err_cnt++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic hi(input int n);
    bus.sq_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic lo(input int n);
    bus.sq_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input int w [8], input bit glitch = 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (w[k] > 0) begin
        if (glitch && k == 0) begin
          hi(40);
          lo(10);
          hi(w[k] - 50);
        end else hi(w[k]);
      end
      lo(GAP);
    end
    lo(9 * GAP);
  endtask
  task automatic check_bank(input string tag, input int w [8]);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s prob[%0d]", tag, k), 64'(bus.prob[k*PW +: PW]), 64'(w[k] > 65535 ? 65535 : w[k]));
  endtask
  task automatic check_sw(input string tag, input int slot, input int exp);
    bus.slot_sel = 3'(slot);
    repeat (2) @(negedge clk);
    check($sformatf("%s slot_width[%0d]", tag, slot), 64'(bus.slot_width), 64'(exp));
  endtask
  initial begin
    rst = 1'b1;
    bus.sq_in = 1'b0;
    bus.slot_sel = 3'd0;
    repeat (3) @(negedge clk);
    check("reset prob", 64'(bus.prob), 64'd0);
    check("reset slot_width", 64'(bus.slot_width), 64'd0);
    check("reset locked", 64'(bus.locked), 64'd0);
    check("reset frame_valid", 64'(bus.frame_valid), 64'd0);
    rst = 1'b0;
    lo(20 * GAP);
    send_frame(fa);
    check("hunt locked", 64'(bus.locked), 64'd0);
    check("hunt frames", 64'(fv_cnt), 64'd0);
    send_frame(fa);
    check("lock locked", 64'(bus.locked), 64'd1);
    check("lock frames", 64'(fv_cnt), 64'd1);
    check_bank("lock", fa);
    send_frame(fa);
    check("lock2 frames", 64'(fv_cnt), 64'd2);
    check_sw("lock2", 1, 300);
    send_frame(fi);
    check_bank("interior", fi);
    check("interior errs", 64'(err_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      send_frame(fl);
      check_bank($sformatf("leading%0d", i), fl);
    end
    check("leading locked", 64'(bus.locked), 64'd1);
    check("leading frames", 64'(fv_cnt), 64'd6);
    check("leading errs", 64'(err_cnt), 64'd0);
    send_frame(fa, 1'b1);
    check("glitch errs", 64'(err_cnt), 64'd1);
    check("glitch locked", 64'(bus.locked), 64'd0);
    check("glitch frames", 64'(fv_cnt), 64'd6);
    check_bank("glitch hold", fl);
    send_frame(fa);
    check("relock locked", 64'(bus.locked), 64'd1);
    check("relock frames", 64'(fv_cnt), 64'd7);
    check_bank("relock", fa);
    send_frame(fs);
    check_bank("saturate", fs);
    check_sw("saturate", 0, 70000);
    bus.sq_in = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async prob", 64'(bus.prob), 64'd0);
    check("async slot_width", 64'(bus.slot_width), 64'd0);
    check("async locked", 64'(bus.locked), 64'd0);
    check("async frame_valid", 64'(bus.frame_valid), 64'd0);
    check("async sync_err", 64'(bus.sync_err), 64'd0);
    check("async state", 64'(dut.state), 64'(HUNT));
    @(negedge clk);
    rst = 1'b0;
    bus.sq_in = 1'b0;
    for (int k = 0; k < 8; k++) check_sw("post reset", k, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
